// File: rtl/st_mlbmiss_replay_pkg.sv
// ---------------------------------------------------------------------------
// st_mlbmiss_replay_pkg
//   Shared types for the store MLB-miss replay queue:
//     entry_st_e    - per-entry translation progress (PEND / WALK / READY)
//     walk_st_e     - page-walk request FSM states
//     rpl_payload_t - store payload carried from capture to replay
// ---------------------------------------------------------------------------
package st_mlbmiss_replay_pkg;

  localparam int RPL_ADDR_W = 44;

  typedef enum logic [1:0] {
    ST_PEND  = 2'd0,  // waiting for a walk to be issued
    ST_WALK  = 2'd1,  // walk outstanding for this entry
    ST_READY = 2'd2   // translation resident (or known faulting)
  } entry_st_e;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_REQ  = 2'd1,
    W_WAIT = 2'd2
  } walk_st_e;

  typedef struct packed {
    logic [RPL_ADDR_W-1:0] addr;
    logic [3:0]            attr;
    logic [8:0]            lsq;
    logic [9:0]            ii;
    logic [5:0]            wq;
    logic                  thread;
  } rpl_payload_t;

endpackage

// File: rtl/smlb_oldest_pick.sv
// ---------------------------------------------------------------------------
// smlb_oldest_pick
//   Rotate-by-head priority encoder: returns the slot closest to (and
//   including) head whose mask bit is set, i.e. the oldest matching entry
//   of a circular queue.
//   Ports:
//     mask  in  DEPTH  candidate entries
//     head  in  IDX_W  index of the oldest queue slot
//     found out 1      at least one mask bit set
//     idx   out IDX_W  slot index of the oldest candidate
// ---------------------------------------------------------------------------
module smlb_oldest_pick #(
  parameter int DEPTH = 8,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0] mask,
  input  logic [IDX_W-1:0] head,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  logic [IDX_W-1:0] slot;

  // Scan from youngest offset down to offset 0 so the oldest hit is the
  // last one written. Slot arithmetic wraps because DEPTH is a power of 2.
  always_comb begin
    // NOTE: every output of a combinational block gets a default up front;
    // a path that leaves one unassigned would infer a latch.
    found = 1'b0;
    idx   = '0;
    slot  = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      slot = head + IDX_W'(i);
      if (mask[slot]) begin
        found = 1'b1;
        idx   = slot;
      end
    end
  end

endmodule

// File: rtl/st_mlbmiss_replay.sv
// ---------------------------------------------------------------------------
// st_mlbmiss_replay
//   Store MLB-miss replay queue. Captures stores that missed the MLB, walks
//   one page at a time (oldest pending first) and replays each store into
//   the address stage once its translation is resident; faulting walks are
//   replayed with rpl_fault so the address stage raises the page fault.
//
//   Ports:
//     clk, rst                 clock, synchronous active-high reset
//     except, except_thread    flush all entries of a thread
//     miss_*                   store that missed the MLB this cycle
//     full                     <= one free slot left; upstream holds issue
//     walk_req/walk_tlb/walk_ack  page-walk request handshake
//     fill_en/fill_tlb/fill_fault walk completion
//     rpl_hold                 address-stage bus busy, no replay
//     rpl_*                    replayed store
//
//   Build option: SMLB_DEDUP_EN - a fill resolves every queued entry with
//   the same MLB key, so repeated misses to one page share a single walk.
// ---------------------------------------------------------------------------
module st_mlbmiss_replay
  import st_mlbmiss_replay_pkg::*;
#(
  parameter int DEPTH        = 8,
  parameter int TLB_IP_WIDTH = 52
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    except,
  input  logic                    except_thread,
  input  logic                    miss_en,
  input  logic [64:0]             miss_addr,
  input  logic [TLB_IP_WIDTH-1:0] miss_tlb,
  input  logic [8:0]              miss_LSQ,
  input  logic [9:0]              miss_II,
  input  logic [5:0]              miss_WQ,
  input  logic                    miss_thread,
  input  logic [3:0]              miss_attr,
  output logic                    full,
  output logic                    walk_req,
  output logic [TLB_IP_WIDTH-1:0] walk_tlb,
  input  logic                    walk_ack,
  input  logic                    fill_en,
  input  logic [TLB_IP_WIDTH-1:0] fill_tlb,
  input  logic                    fill_fault,
  input  logic                    rpl_hold,
  output logic                    rpl_en,
  output logic [43:0]             rpl_addr,
  output logic [3:0]              rpl_attr,
  output logic [8:0]              rpl_LSQ,
  output logic [9:0]              rpl_II,
  output logic [5:0]              rpl_WQ,
  output logic                    rpl_thread,
  output logic                    rpl_fault
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  // Queue storage
  logic [DEPTH-1:0]        valid_q, valid_d;
  logic [DEPTH-1:0]        fault_q, fault_d;
  entry_st_e               st_q  [DEPTH];
  entry_st_e               st_d  [DEPTH];
  logic [TLB_IP_WIDTH-1:0] tlb_q [DEPTH];
  logic [TLB_IP_WIDTH-1:0] tlb_d [DEPTH];
  rpl_payload_t            pay_q [DEPTH];
  rpl_payload_t            pay_d [DEPTH];
  logic [PTR_W-1:0]        head_q, head_d, tail_q, tail_d;

  // Walker
  walk_st_e                wstate_q, wstate_d;
  logic [TLB_IP_WIDTH-1:0] wkey_q, wkey_d;
  logic [IDX_W-1:0]        widx_q, widx_d;
  logic                    wlive_q, wlive_d;  // WALK entry not flushed

  logic [PTR_W-1:0] count;
  logic [IDX_W-1:0] head_idx, tail_idx, pick_idx;
  logic [DEPTH-1:0] pend_mask;
  logic             pick_found, start_walk, fill_hit;
  logic             not_empty, rpl_fire, head_skip, alloc;

  // Upper address bits are not replayed.
  logic unused_addr_hi;
  assign unused_addr_hi = ^miss_addr[64:44];

  assign head_idx   = head_q[IDX_W-1:0];
  assign tail_idx   = tail_q[IDX_W-1:0];
  assign count      = tail_q - head_q;
  assign not_empty  = (count != '0);
  // One slot stays in reserve for a miss already issued before full is seen.
  assign full       = (count >= PTR_W'(DEPTH - 1));

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      pend_mask[i] = valid_q[i] && (st_q[i] == ST_PEND);
    end
  end

  smlb_oldest_pick #(.DEPTH(DEPTH)) u_pick (
    .mask  (pend_mask),
    .head  (head_idx),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign start_walk = (wstate_q == W_IDLE) && pick_found;
  // Fills are only consumed while waiting; a stale fill after reset is ignored.
  assign fill_hit   = (wstate_q == W_WAIT) && fill_en && (fill_tlb == wkey_q);

  assign rpl_fire  = not_empty && valid_q[head_idx] && (st_q[head_idx] == ST_READY)
                     && !rpl_hold && !except;
  // Flushed entries leave holes that are retired one per cycle from head.
  assign head_skip = not_empty && !valid_q[head_idx];
  assign alloc     = miss_en && (count != PTR_W'(DEPTH))
                     && !(except && (miss_thread == except_thread));

  // ---------------- Walker FSM ----------------
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignment so every flop samples
    // the pre-edge values regardless of process ordering.
    if (rst) wstate_q <= W_IDLE;
    else     wstate_q <= wstate_d;
  end

  always_comb begin
    wstate_d = wstate_q;
    case (wstate_q)
      W_IDLE:  if (pick_found) wstate_d = W_REQ;
      W_REQ:   if (walk_ack)   wstate_d = W_WAIT;
      W_WAIT:  if (fill_hit)   wstate_d = W_IDLE;
      default: wstate_d = W_IDLE;
    endcase
  end

  always_comb begin
    walk_req = (wstate_q == W_REQ);
    walk_tlb = wkey_q;
  end

  // ---------------- Walk context ----------------
  always_comb begin
    wkey_d  = wkey_q;
    widx_d  = widx_q;
    wlive_d = wlive_q;
    if (start_walk) begin
      wkey_d  = tlb_q[pick_idx];
      widx_d  = pick_idx;
      wlive_d = !(except && (pay_q[pick_idx].thread == except_thread));
    end else if (fill_hit) begin
      wlive_d = 1'b0;
    end else if (except && (pay_q[widx_q].thread == except_thread)) begin
      // Slot may be reused before the fill returns; never touch it then.
      wlive_d = 1'b0;
    end
  end

  // ---------------- Queue update ----------------
  always_comb begin
    valid_d = valid_q;
    fault_d = fault_q;
    st_d    = st_q;
    tlb_d   = tlb_q;
    pay_d   = pay_q;
    head_d  = head_q;
    tail_d  = tail_q;

    if (start_walk) st_d[pick_idx] = ST_WALK;

`ifdef SMLB_DEDUP_EN
    if (fill_hit) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (valid_q[i] && (st_q[i] != ST_READY) && (tlb_q[i] == wkey_q)) begin
          st_d[i]    = ST_READY;
          fault_d[i] = fill_fault;
        end
      end
    end
`else
    if (fill_hit && wlive_q) begin
      st_d[widx_q]    = ST_READY;
      fault_d[widx_q] = fill_fault;
    end
`endif

    if (except) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (pay_q[i].thread == except_thread) valid_d[i] = 1'b0;
      end
    end

    if (rpl_fire || head_skip) begin
      valid_d[head_idx] = 1'b0;
      head_d            = head_q + PTR_W'(1);
    end

    if (alloc) begin
      valid_d[tail_idx] = 1'b1;
      st_d[tail_idx]    = ST_PEND;
      fault_d[tail_idx] = 1'b0;
      tlb_d[tail_idx]   = miss_tlb;
      pay_d[tail_idx]   = '{addr: miss_addr[43:0], attr: miss_attr, lsq: miss_LSQ,
                            ii: miss_II, wq: miss_WQ, thread: miss_thread};
      tail_d            = tail_q + PTR_W'(1);
    end
  end

`ifdef SMLB_DEDUP_EN
  logic unused_wlive;
  assign unused_wlive = wlive_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      wkey_q  <= '0;
      widx_q  <= '0;
      wlive_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      wkey_q  <= wkey_d;
      widx_q  <= widx_d;
      wlive_q <= wlive_d;
    end
  end

  // NOTE: entry contents are qualified by valid_q, so the storage array is
  // left unreset; only the valid bits and pointers need a known value.
  always_ff @(posedge clk) begin
    st_q    <= st_d;
    fault_q <= fault_d;
    tlb_q   <= tlb_d;
    pay_q   <= pay_d;
  end

  // ---------------- Replay port ----------------
  // Driven from registered entry state; gated to zero when not replaying.
  always_comb begin
    rpl_en     = rpl_fire;
    rpl_addr   = '0;
    rpl_attr   = '0;
    rpl_LSQ    = '0;
    rpl_II     = '0;
    rpl_WQ     = '0;
    rpl_thread = 1'b0;
    rpl_fault  = 1'b0;
    if (rpl_fire) begin
      rpl_addr   = pay_q[head_idx].addr;
      rpl_attr   = pay_q[head_idx].attr;
      rpl_LSQ    = pay_q[head_idx].lsq;
      rpl_II     = pay_q[head_idx].ii;
      rpl_WQ     = pay_q[head_idx].wq;
      rpl_thread = pay_q[head_idx].thread;
      rpl_fault  = fault_q[head_idx];
    end
  end

endmodule

// File: tb/tb_st_mlbmiss_replay.sv
// ---------------------------------------------------------------------------
// tb_st_mlbmiss_replay
//   Directed self-checking bench for st_mlbmiss_replay (DEPTH=8). Inputs are
//   driven 1ns after the rising edge; outputs are sampled on the falling edge.
//   Expectations follow the SMLB_DEDUP_EN build option when it is defined.
// ---------------------------------------------------------------------------
module tb_st_mlbmiss_replay;

  localparam int DEPTH = 8;
  localparam int TW    = 52;

  localparam logic [TW-1:0] K1 = 52'h0_0011_1111_0001;
  localparam logic [TW-1:0] K2 = 52'h0_0022_2222_0002;
  localparam logic [TW-1:0] K3 = 52'h0_0033_3333_0003;
  localparam logic [TW-1:0] K4 = 52'h0_0044_4444_0004;
  localparam logic [TW-1:0] K5 = 52'h0_0055_5555_0005;
  localparam logic [TW-1:0] K6 = 52'h0_0066_6666_0006;
  localparam logic [TW-1:0] K7 = 52'h0_0077_7777_0007;
  localparam logic [TW-1:0] K8 = 52'h0_0088_8888_0008;
  localparam logic [TW-1:0] K9 = 52'h0_0099_9999_0009;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          except = 1'b0, except_thread = 1'b0;
  logic          miss_en = 1'b0;
  logic [64:0]   miss_addr = '0;
  logic [TW-1:0] miss_tlb = '0;
  logic [8:0]    miss_LSQ = '0;
  logic [9:0]    miss_II = '0;
  logic [5:0]    miss_WQ = '0;
  logic          miss_thread = 1'b0;
  logic [3:0]    miss_attr = '0;
  logic          full, walk_req;
  logic [TW-1:0] walk_tlb;
  logic          walk_ack = 1'b0, fill_en = 1'b0, fill_fault = 1'b0;
  logic [TW-1:0] fill_tlb = '0;
  logic          rpl_hold = 1'b0;
  logic          rpl_en;
  logic [43:0]   rpl_addr;
  logic [3:0]    rpl_attr;
  logic [8:0]    rpl_LSQ;
  logic [9:0]    rpl_II;
  logic [5:0]    rpl_WQ;
  logic          rpl_thread, rpl_fault;

  st_mlbmiss_replay #(.DEPTH(DEPTH), .TLB_IP_WIDTH(TW)) dut (
    .clk(clk), .rst(rst), .except(except), .except_thread(except_thread),
    .miss_en(miss_en), .miss_addr(miss_addr), .miss_tlb(miss_tlb),
    .miss_LSQ(miss_LSQ), .miss_II(miss_II), .miss_WQ(miss_WQ),
    .miss_thread(miss_thread), .miss_attr(miss_attr), .full(full),
    .walk_req(walk_req), .walk_tlb(walk_tlb), .walk_ack(walk_ack),
    .fill_en(fill_en), .fill_tlb(fill_tlb), .fill_fault(fill_fault),
    .rpl_hold(rpl_hold), .rpl_en(rpl_en), .rpl_addr(rpl_addr),
    .rpl_attr(rpl_attr), .rpl_LSQ(rpl_LSQ), .rpl_II(rpl_II), .rpl_WQ(rpl_WQ),
    .rpl_thread(rpl_thread), .rpl_fault(rpl_fault)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int req_cyc = 0, fill_cyc = 0, miss_cyc = 0;

  typedef struct {
    logic [8:0]  lsq;
    logic [9:0]  ii;
    logic [5:0]  wq;
    logic [43:0] addr;
    logic [3:0]  attr;
    logic        thr;
    logic        fault;
    int          cyc;
  } rpl_ev_t;

  rpl_ev_t       rpls[$];
  logic [TW-1:0] walks[$];

  // Passive recorder of accepted walk requests and replays.
  always @(negedge clk) begin
    if (!rst) begin
      if (walk_req && walk_ack) walks.push_back(walk_tlb);
      if (rpl_en) rpls.push_back('{rpl_LSQ, rpl_II, rpl_WQ, rpl_addr, rpl_attr,
                                   rpl_thread, rpl_fault, cyc});
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [43:0] exp_addr(input logic [8:0] lsq);
    return {14'h1234, 21'h0, lsq};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    rpls.delete();
    walks.delete();
  endtask

  task automatic do_miss(input logic [TW-1:0] key, input logic thr, input logic [8:0] lsq);
    miss_en     = 1'b1;
    miss_addr   = {21'h15555, 14'h1234, 21'h0, lsq};
    miss_tlb    = key;
    miss_LSQ    = lsq;
    miss_II     = {1'b0, lsq};
    miss_WQ     = lsq[5:0];
    miss_thread = thr;
    miss_attr   = lsq[3:0] ^ 4'hA;
    miss_cyc    = cyc;
    tick();
    miss_en     = 1'b0;
  endtask

  task automatic wait_req(input logic [TW-1:0] key);
    int n;
    n = 0;
    @(negedge clk);
    while (!walk_req && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!walk_req) check("walk_req_timeout", walk_req, 1);
    else begin
      req_cyc = cyc;
      check("walk_tlb", walk_tlb, key);
    end
  endtask

  // Holds off walk_ack for d cycles (checking the request stays stable),
  // then accepts it in the following cycle.
  task automatic ack_walk(input logic [TW-1:0] key, input int d);
    for (int i = 0; i < d; i++) begin
      tick();
      @(negedge clk);
      check("walk_req_held", walk_req, 1);
      check("walk_tlb_stable", walk_tlb, key);
    end
    tick();
    walk_ack = 1'b1;
    tick();
    walk_ack = 1'b0;
  endtask

  task automatic fill_walk(input logic [TW-1:0] key, input logic fault, input int d);
    repeat (d) tick();
    fill_en    = 1'b1;
    fill_tlb   = key;
    fill_fault = fault;
    fill_cyc   = cyc;
    tick();
    fill_en    = 1'b0;
    fill_fault = 1'b0;
  endtask

  task automatic serve(input logic [TW-1:0] key, input logic fault);
    wait_req(key);
    ack_walk(key, 1);
    fill_walk(key, fault, 2);
  endtask

  task automatic check_rpl(input int n, input logic [8:0] lsq, input logic thr,
                           input logic fault, input int exp_cyc);
    if (n >= rpls.size()) check("rpl_missing", rpls.size(), n + 1);
    else begin
      check("rpl_lsq",   rpls[n].lsq,   lsq);
      check("rpl_ii",    rpls[n].ii,    {1'b0, lsq});
      check("rpl_wq",    rpls[n].wq,    lsq[5:0]);
      check("rpl_addr",  rpls[n].addr,  exp_addr(lsq));
      check("rpl_attr",  rpls[n].attr,  lsq[3:0] ^ 4'hA);
      check("rpl_thr",   rpls[n].thr,   thr);
      check("rpl_fault", rpls[n].fault, fault);
      if (exp_cyc >= 0) check("rpl_cyc", rpls[n].cyc, exp_cyc);
    end
  endtask

  initial begin
    #400000;
    $fatal(1, "watchdog expired");
  end

  initial begin
    int fc[3];
    int f0, f1;

    // ---------------- reset ----------------
    repeat (3) tick();
    @(negedge clk);
    check("rst_full", full, 0);
    check("rst_walk_req", walk_req, 0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_full", full, 0);
    check("rst_walk_req", walk_req, 0);
    check("rst_walk_tlb", walk_tlb, 0);
    check("rst_rpl_en", rpl_en, 0);
    check("rst_rpl_addr", rpl_addr, 0);
    check("rst_rpl_lsq", rpl_LSQ, 0);
    check("rst_rpl_fault", rpl_fault, 0);

    // ---------------- T1: single miss ----------------
    tick();
    clear_logs();
    do_miss(K1, 1'b0, 9'd1);
    wait_req(K1);
    check("t1_req_latency", req_cyc, miss_cyc + 2);
    ack_walk(K1, 1);
    fill_walk(K1, 1'b0, 4);
    repeat (4) tick();
    check("t1_walks", walks.size(), 1);
    if (walks.size() > 0) check("t1_walk_key", walks[0], K1);
    check("t1_rpl_count", rpls.size(), 1);
    check_rpl(0, 9'd1, 1'b0, 1'b0, fill_cyc + 1);

    // ---------------- T2: three misses, same key ----------------
    clear_logs();
    do_miss(K2, 1'b0, 9'd2);
    do_miss(K2, 1'b0, 9'd3);
    do_miss(K2, 1'b0, 9'd4);
`ifdef SMLB_DEDUP_EN
    serve(K2, 1'b0);
    f0 = fill_cyc;
    repeat (6) tick();
    check("t2_walks", walks.size(), 1);
    check("t2_rpl_count", rpls.size(), 3);
    for (int i = 0; i < 3; i++) check_rpl(i, 9'(2 + i), 1'b0, 1'b0, f0 + 1 + i);
`else
    for (int k = 0; k < 3; k++) begin
      serve(K2, 1'b0);
      fc[k] = fill_cyc;
    end
    repeat (4) tick();
    check("t2_walks", walks.size(), 3);
    check("t2_rpl_count", rpls.size(), 3);
    for (int i = 0; i < 3; i++) check_rpl(i, 9'(2 + i), 1'b0, 1'b0, fc[i] + 1);
`endif

    // ---------------- T3: faulting fill ----------------
    clear_logs();
    do_miss(K3, 1'b0, 9'd5);
    do_miss(K4, 1'b0, 9'd6);
    serve(K3, 1'b1);
    f0 = fill_cyc;
    serve(K4, 1'b0);
    f1 = fill_cyc;
    repeat (4) tick();
    check("t3_walks", walks.size(), 2);
    check("t3_rpl_count", rpls.size(), 2);
    check_rpl(0, 9'd5, 1'b0, 1'b1, f0 + 1);
    check_rpl(1, 9'd6, 1'b0, 1'b0, f1 + 1);

    // ---------------- T4: full threshold ----------------
    clear_logs();
    for (int i = 0; i < DEPTH - 1; i++) begin
      do_miss(K5, 1'b0, 9'(10 + i));
      @(negedge clk);
      check("t4_full_fill", full, (i == DEPTH - 2));
    end
    wait_req(K5);
    ack_walk(K5, 1);
    fill_walk(K5, 1'b0, 2);
    @(negedge clk);
    check("t4_rpl_en", rpl_en, 1);
    check("t4_full_at_replay", full, 1);
    tick();
    @(negedge clk);
    check("t4_full_release", full, 0);
`ifndef SMLB_DEDUP_EN
    repeat (DEPTH - 2) serve(K5, 1'b0);
`endif
    repeat (10) tick();
`ifdef SMLB_DEDUP_EN
    check("t4_walks", walks.size(), 1);
`else
    check("t4_walks", walks.size(), DEPTH - 1);
`endif
    check("t4_rpl_count", rpls.size(), DEPTH - 1);
    for (int i = 0; i < DEPTH - 1; i++) check_rpl(i, 9'(10 + i), 1'b0, 1'b0, -1);

    // ---------------- T5: flush during walk ----------------
    clear_logs();
    do_miss(K6, 1'b1, 9'd20);
    do_miss(K7, 1'b0, 9'd21);
    wait_req(K6);
    ack_walk(K6, 1);
    except        = 1'b1;
    except_thread = 1'b1;
    tick();
    except        = 1'b0;
    fill_walk(K6, 1'b0, 2);
    serve(K7, 1'b0);
    f0 = fill_cyc;
    repeat (4) tick();
    check("t5_walks", walks.size(), 2);
    if (walks.size() > 1) check("t5_walk_key2", walks[1], K7);
    check("t5_rpl_count", rpls.size(), 1);
    check_rpl(0, 9'd21, 1'b0, 1'b0, f0 + 1);

    // ---------------- T6: replay hold ----------------
    clear_logs();
    rpl_hold = 1'b1;
    do_miss(K8, 1'b0, 9'd30);
    serve(K8, 1'b0);
    @(negedge clk);
    check("t6_held", rpl_en, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge clk);
      check("t6_held", rpl_en, 0);
    end
    tick();
    rpl_hold = 1'b0;
    repeat (3) tick();
    check("t6_rpl_count", rpls.size(), 1);
    check_rpl(0, 9'd30, 1'b0, 1'b0, fill_cyc + 5);

    // ---------------- T7: reset mid-walk ----------------
    clear_logs();
    do_miss(K9, 1'b0, 9'd40);
    wait_req(K9);
    ack_walk(K9, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    fill_walk(K9, 1'b0, 1);
    repeat (4) tick();
    @(negedge clk);
    check("t7_walk_req", walk_req, 0);
    check("t7_full", full, 0);
    check("t7_rpl_count", rpls.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
